// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Streams a program byte-wise into instruction memory and holds the
//            core in reset until a complete load has landed.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter int DEPTH_WORDS = 32,
    parameter bit BOOT_HELD   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  num_words_i,
    input  logic        abort_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic [31:0] core_pc_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        core_rst_n_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);

    state_t      state_q,    state_d;
    logic [5:0]  n_q,        n_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q,      asm_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        loaded_q,   loaded_d;

    logic [5:0]  w_n_clamped;
    logic [5:0]  w_word_inc;
    logic        w_accept;

    // Clamp the requested length to the memory capacity.
    always_comb begin
        if ({26'd0, num_words_i} > C_DEPTH) begin
            w_n_clamped = C_DEPTH[5:0];
        end else begin
            w_n_clamped = num_words_i;
        end
    end

    assign w_word_inc = word_cnt_q + 6'd1;
    assign w_accept   = rx_ready_o & rx_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= 6'd0;
            word_cnt_q <= 6'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            wdata_q    <= 32'd0;
            loaded_q   <= ~BOOT_HELD;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            loaded_q   <= loaded_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        loaded_d   = loaded_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d        = w_n_clamped;
                    word_cnt_d = 6'd0;
                    byte_cnt_d = 2'd0;
                    state_d    = (w_n_clamped == 6'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d    = S_IDLE;
                    byte_cnt_d = 2'd0;
                    asm_d      = 24'd0;
                    loaded_d   = 1'b0;
                end else if (w_accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    asm_d[7:0]   = rx_data_i;
                        2'd1:    asm_d[15:8]  = rx_data_i;
                        2'd2:    asm_d[23:16] = rx_data_i;
                        default: begin
                            wdata_d = {rx_data_i, asm_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (abort_i) begin
                    state_d  = S_IDLE;
                    loaded_d = 1'b0;
                end else begin
                    word_cnt_d = w_word_inc;
                    state_d    = (w_word_inc == n_q) ? S_DONE : S_LOAD;
                end
            end
            default: begin
                state_d  = S_IDLE;
                loaded_d = ~abort_i;
            end
        endcase
    end

    // Memory port belongs to the core whenever the loader is idle.
    assign mem_addr_o   = (state_q == S_IDLE) ? core_pc_i
                                              : {24'd0, word_cnt_q, 2'b00};
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = (state_q == S_WRITE) & ~abort_i;
    assign rx_ready_o   = (state_q == S_LOAD) & ~abort_i;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE) & ~abort_i;
    assign core_rst_n_o = loaded_q & (state_q == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Scoreboard bench for imem_boot_loader (BOOT_HELD=1, 32 words).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  num_words_i = 6'd0;
    logic        abort_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [31:0] core_pc_i = 32'd0;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic        core_rst_n_o;
    logic        busy_o;
    logic        done_o;

    imem_boot_loader #(.DEPTH_WORDS(DEPTH), .BOOT_HELD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_words_i(num_words_i),
        .abort_i(abort_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .rx_ready_o(rx_ready_o), .core_pc_i(core_pc_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .core_rst_n_o(core_rst_n_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t         exp_wr[$];
    int          exp_done = 0;
    int          wr_seen = 0;
    logic [31:0] last_addr = 32'd0;
    int unsigned done_cyc = 0;
    logic [7:0]  prog [8] = '{8'h93, 8'h00, 8'h00, 8'h01, 8'h93, 8'h01, 8'h40, 8'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor: every write and done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we_o === 1'b1) begin
                wr_t e;
                wr_seen++;
                last_addr = mem_addr_o;
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_addr_o, e.a);
                    check("wr_data", mem_wdata_o, e.d);
                end
            end
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                if (exp_done == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_done--;
                    check("done_no_we", {31'd0, mem_we_o}, 32'd0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int unsigned acc_cyc);
        int k = 0;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        forever begin
            @(negedge clk);
            if (rx_ready_o === 1'b1) break;
            k++;
            if (k > 50) begin
                fail_now("rx_ready_timeout");
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_o === 1'b1 && k < 200);
        check("idle_reached", {31'd0, busy_o}, 32'd0);
    endtask

    // Reference model: words land at consecutive word addresses, bytes little-endian.
    task automatic do_load(input int nw, input int gap_after, input int gap_len,
                           input int abort_at, input int busy_start_at, input bit fixed,
                           output int unsigned first_cyc, output int unsigned start_cyc);
        int          n;
        int unsigned acc;
        logic [7:0]  b;
        int unsigned wb [4];
        wr_t         e;
        n = (nw > DEPTH) ? DEPTH : nw;
        first_cyc = 0;
        @(posedge clk);
        #1;
        if (n == 0) exp_done++;
        start_i     = 1'b1;
        num_words_i = 6'(nw);
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        num_words_i = 6'($urandom);
        for (int i = 0; i < 4 * n; i++) begin
            if (i == abort_at) begin
                abort_i = 1'b1;
                @(posedge clk);
                #1;
                abort_i = 1'b0;
                wait_idle();
                return;
            end
            if (i == busy_start_at) begin
                start_i     = 1'b1;
                num_words_i = 6'd0;
            end
            b = fixed ? prog[i % 8] : 8'($urandom);
            wb[i % 4] = b;
            send_byte(b, acc);
            start_i = 1'b0;
            if (i == 0) first_cyc = acc;
            if (i % 4 == 3) begin
                e.a = 32'((i / 4) * 4);
                e.d = 32'(wb[0] + wb[1] * 256 + wb[2] * 65536 + wb[3] * 16777216);
                exp_wr.push_back(e);
            end
            if (i == 4 * n - 1) exp_done++;
            if (i == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned f, s;
        int          w0;
        int          nw, ab, bs;
        logic [31:0] pc;
        wr_t         e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", {31'd0, done_o}, 32'd0);
        check("post_rst_ready", {31'd0, rx_ready_o}, 32'd0);
        check("post_rst_wdata", mem_wdata_o, 32'd0);
        check("held_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        core_pc_i = 32'h2C;
        #1;
        check("idle_addr_2c", mem_addr_o, 32'h2C);

        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", {31'd0, busy_o}, 32'd0);

        do_load(2, -1, 0, -1, -1, 1'b1, f, s);
        check("two_word_done_lat", f + 10, done_cyc);
        check("two_word_core_rst_n", {31'd0, core_rst_n_o}, 32'd1);
        check("wdata_hold", mem_wdata_o, 32'h00400193);
        pc = $urandom;
        core_pc_i = pc;
        #1;
        check("idle_addr_rand", mem_addr_o, pc);

        w0 = wr_seen;
        do_load(2, 1, 3, -1, -1, 1'b1, f, s);
        check("gap_done_lat", f + 13, done_cyc);
        check("gap_write_count", 32'(wr_seen - w0), 32'd2);

        w0 = wr_seen;
        do_load(0, -1, 0, -1, -1, 1'b0, f, s);
        check("zero_done_lat", s + 1, done_cyc);
        check("zero_write_count", 32'(wr_seen - w0), 32'd0);
        check("zero_core_rst_n", {31'd0, core_rst_n_o}, 32'd1);

        w0 = wr_seen;
        do_load(40, -1, 0, -1, 9, 1'b0, f, s);
        check("clamp_write_count", 32'(wr_seen - w0), 32'd32);
        check("clamp_last_addr", last_addr, 32'h7C);

        w0 = wr_seen;
        do_load(2, -1, 0, 7, -1, 1'b1, f, s);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        check("abort_write_count", 32'(wr_seen - w0), 32'd1);
        do_load(1, -1, 0, -1, -1, 1'b0, f, s);
        check("reload_addr", last_addr, 32'h0);
        check("reload_core_rst_n", {31'd0, core_rst_n_o}, 32'd1);

        for (int it = 0; it < 10; it++) begin
            nw = $urandom_range(0, 6);
            ab = -1;
            if (nw > 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, 4 * nw - 1);
                if (ab % 4 == 0) ab = ab + 1;
            end
            bs = (nw > 0) ? $urandom_range(0, 4 * nw - 1) : -1;
            do_load(nw, $urandom_range(0, 20), $urandom_range(0, 4), ab, bs, 1'b0, f, s);
            check("rand_core_rst_n", {31'd0, core_rst_n_o}, (ab < 0) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of a load: word 0 lands, the rest is abandoned.
        w0 = wr_seen;
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        num_words_i = 6'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        begin
            int unsigned acc;
            int unsigned wb [4];
            for (int i = 0; i < 6; i++) begin
                wb[i % 4] = $urandom_range(0, 255);
                if (i == 3) begin
                    e.a = 32'd0;
                    e.d = 32'(wb[0] + wb[1] * 256 + wb[2] * 65536 + wb[3] * 16777216);
                    exp_wr.push_back(e);
                end
                send_byte(8'(wb[i % 4]), acc);
            end
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_wdata", mem_wdata_o, 32'd0);
        check("midrst_core_rst_n", {31'd0, core_rst_n_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_valid_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        check("midrst_write_count", 32'(wr_seen - w0), 32'd1);

        check("leftover_writes", 32'(exp_wr.size()), 32'd0);
        check("leftover_done", 32'(exp_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 32: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BOOT_HELD, default 0: 1 = core held in reset from power-up until the first completed load.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a program load; sampled in IDLE only.
REQ-006 num_words  input  6  words to load; latched on accepted start.
REQ-007 abort  input  1  cancel an in-progress load.
REQ-008 rx_data  input  8  incoming program byte.
REQ-009 rx_valid  input  1  rx_data valid.
REQ-010 rx_ready  output  1  loader accepts a byte this cycle.
REQ-011 core_pc  input  32  core fetch address.
REQ-012 mem_addr  output  32  byte address to instruction memory.
REQ-013 mem_wdata  output  32  write word to instruction memory.
REQ-014 mem_we  output  1  instruction-memory write enable.
REQ-015 core_rst_n  output  1  active-low reset to the core.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on load completion.

Function
REQ-018 States SHALL be IDLE, LOAD, WRITE, DONE, encoded in one state register.
REQ-019 IDLE: mem_addr SHALL equal core_pc combinationally; mem_we=0; rx_ready=0.
REQ-020 IDLE + start=1: latch N = min(num_words, DEPTH_WORDS); clear word_cnt and byte_cnt; go to LOAD, or to DONE when N=0.
REQ-021 LOAD: rx_ready=1; byte accepted only when rx_valid & rx_ready.
REQ-022 Byte assembly little-endian: byte k (k=0..3) of a word goes to bits [8k+7:8k]; byte_cnt wraps 3->0.
REQ-023 Acceptance of byte 3 SHALL transition to WRITE on the next edge.
REQ-024 WRITE lasts exactly one cycle: mem_we=1, mem_addr={word_cnt,2'b00} zero-extended, mem_wdata=assembled word, rx_ready=0.
REQ-025 After WRITE: word_cnt increments; go to DONE if incremented word_cnt==N, else LOAD.
REQ-026 Minimum throughput: 5 cycles per word (4 byte cycles + 1 write cycle).
REQ-027 DONE lasts one cycle: done=1, mem_we=0; set loaded flag; next state IDLE.
REQ-028 core_rst_n = loaded & (state==IDLE); core held in reset throughout a load and during DONE.
REQ-029 abort=1 in LOAD/WRITE/DONE: next state IDLE, no write in that cycle, partial word discarded, loaded cleared; abort wins over rx handshake and WRITE.
REQ-030 abort in IDLE SHALL be ignored; start while busy SHALL be ignored.
REQ-031 rx_valid low in LOAD: hold state and partial word indefinitely (no timeout).
REQ-032 mem_wdata SHALL hold its last assembled value outside WRITE; only mem_we qualifies it.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE, word_cnt=0, byte_cnt=0, assembly register=0, N=0, done=0.
REQ-034 On reset, loaded SHALL be set to !BOOT_HELD, so core_rst_n=1 after reset when BOOT_HELD=0 and 0 when BOOT_HELD=1.
REQ-035 Reset asserted mid-load SHALL abandon the load with no further mem_we pulse.

Verification
REQ-036 start, num_words=2, bytes 93 00 00 01 93 01 40 00 back-to-back -> mem_we at addr 0x0 data 0x01000093, then addr 0x4 data 0x00400193; done pulse 10 cycles after first byte; core_rst_n returns 1.
REQ-037 Same load with rx_valid low 3 cycles between bytes 1 and 2 -> identical writes, done delayed by 3 cycles, no extra mem_we.
REQ-038 num_words=0 -> DONE next cycle, no mem_we, done pulse, core_rst_n=1.
REQ-039 num_words=40, DEPTH_WORDS=32 -> exactly 32 writes, last at addr 0x7C.
REQ-040 abort after byte 2 of word 1 -> IDLE, no write, core_rst_n stays 0; new start then loads from addr 0x0.
REQ-041 BOOT_HELD=1, release reset -> core_rst_n=0 until a load completes; in IDLE core_pc=0x2C drives mem_addr=0x2C.
